// File: rtl/pipeline_three_permute_pkg.sv
// Shared flit layout, direction encoding and routing helper for the router stages.
package router_pkg;

    localparam int unsigned FLIT_W  = 11;
    localparam int unsigned VALID_B = 10;
    localparam int unsigned DX_HI   = 9;
    localparam int unsigned DY_HI   = 7;
    localparam int unsigned TAG_W   = 6;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_e;

    // Flit plus the sideband fixed at stage 1 and carried with it.
    typedef struct packed {
        logic [FLIT_W-1:0] flit;
        dir_e              dir;
        logic              golden;
        logic              prio;
    } flit_sb_t;

    typedef struct packed {
        logic [FLIT_W-1:0] flit;
        dir_e              dir;
    } lane_t;

    function automatic dir_e prod_dir(input logic [FLIT_W-1:0] f,
                                      input logic [1:0] x, input logic [1:0] y);
        logic [1:0] dx;
        logic [1:0] dy;
        dx = f[DX_HI -: 2];
        dy = f[DY_HI -: 2];
        if (dx > x)      return DIR_E;
        else if (dx < x) return DIR_W;
        else if (dy > y) return DIR_N;
        else if (dy < y) return DIR_S;
        else             return DIR_N;
    endfunction

endpackage

// File: rtl/pipeline_three_permute_arb.sv
// 2x2 deflection arbiter: golden input wins, prio breaks ties, loser takes the other lane.
module perm_arb_2x2
    import router_pkg::*;
#(
    parameter type T = logic [FLIT_W-1:0]
) (
    input  T     i_d0,
    input  T     i_d1,
    input  logic i_v0,
    input  logic i_v1,
    input  logic i_gold0,
    input  logic i_gold1,
    input  logic i_want0,
    input  logic i_want1,
    input  logic i_prio,
    output T     o_lane0,
    output T     o_lane1
);

    logic w_pick1;
    logic w_win_want;
    T     w_win;
    T     w_lose;

    always_comb begin
        o_lane0    = '0;
        o_lane1    = '0;
        w_pick1    = (i_gold0 != i_gold1) ? i_gold1 : i_prio;
        w_win      = w_pick1 ? i_d1 : i_d0;
        w_lose     = w_pick1 ? i_d0 : i_d1;
        w_win_want = w_pick1 ? i_want1 : i_want0;
        if (i_v0 && i_v1) begin
            if (w_win_want) begin
                o_lane1 = w_win;
                o_lane0 = w_lose;
            end else begin
                o_lane0 = w_win;
                o_lane1 = w_lose;
            end
        end else if (i_v0) begin
            if (i_want0) o_lane1 = i_d0;
            else         o_lane0 = i_d0;
        end else if (i_v1) begin
            if (i_want1) o_lane1 = i_d1;
            else         o_lane0 = i_d1;
        end
    end

endmodule

// File: rtl/pipeline_three_permute.sv
// Router stage three: two-level 2x2 deflection permutation of N/S/E/W flits, two register stages.
module pipeline_three_permute
    import router_pkg::*;
#(
    parameter logic [1:0]  X_COORD      = 2'd0,
    parameter logic [1:0]  Y_COORD      = 2'd0,
    parameter int unsigned GOLDEN_EPOCH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] nxt,
    input  logic [FLIT_W-1:0] sxt,
    input  logic [FLIT_W-1:0] ext,
    input  logic [FLIT_W-1:0] wxt,
    output logic [FLIT_W-1:0] nout,
    output logic [FLIT_W-1:0] sout,
    output logic [FLIT_W-1:0] eout,
    output logic [FLIT_W-1:0] wout,
    output logic [2:0]        defl_cnt,
    output logic [TAG_W-1:0]  golden_tag
);

    localparam int unsigned     EP_W    = (GOLDEN_EPOCH > 2) ? $clog2(GOLDEN_EPOCH) : 1;
    localparam logic [EP_W-1:0] EP_LAST = EP_W'(GOLDEN_EPOCH - 1);

    logic [EP_W-1:0]   r_epoch;
    logic [TAG_W-1:0]  r_tag;
    logic              r_prio;
    logic [FLIT_W-1:0] w_in [4];
    flit_sb_t          w_sb [4];
    flit_sb_t          w_a0, w_a1, w_b0, w_b1;
    flit_sb_t          r_a0, r_a1, r_b0, r_b1;
    lane_t             w_ca, w_cb, w_da, w_db;
    lane_t             w_n, w_s, w_e, w_w;
    logic [2:0]        w_defl;
    logic [FLIT_W-1:0] r_nout, r_sout, r_eout, r_wout;
    logic [2:0]        r_defl;

    assign w_in[0] = nxt;
    assign w_in[1] = sxt;
    assign w_in[2] = ext;
    assign w_in[3] = wxt;

    // Empty slots collapse to all-zero so stray payload bits never reach the outputs.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            w_sb[i] = '0;
            if (w_in[i][VALID_B] == 1'b1) begin
                w_sb[i].flit   = w_in[i];
                w_sb[i].dir    = prod_dir(w_in[i], X_COORD, Y_COORD);
                w_sb[i].golden = (w_in[i][TAG_W-1:0] == r_tag);
                w_sb[i].prio   = r_prio;
            end
        end
    end

    perm_arb_2x2 #(.T(flit_sb_t)) u_arb_a (
        .i_d0(w_sb[0]), .i_d1(w_sb[1]),
        .i_v0(w_sb[0].flit[VALID_B]), .i_v1(w_sb[1].flit[VALID_B]),
        .i_gold0(w_sb[0].golden), .i_gold1(w_sb[1].golden),
        .i_want0(w_sb[0].dir == DIR_E || w_sb[0].dir == DIR_W),
        .i_want1(w_sb[1].dir == DIR_E || w_sb[1].dir == DIR_W),
        .i_prio(r_prio), .o_lane0(w_a0), .o_lane1(w_a1)
    );

    perm_arb_2x2 #(.T(flit_sb_t)) u_arb_b (
        .i_d0(w_sb[2]), .i_d1(w_sb[3]),
        .i_v0(w_sb[2].flit[VALID_B]), .i_v1(w_sb[3].flit[VALID_B]),
        .i_gold0(w_sb[2].golden), .i_gold1(w_sb[3].golden),
        .i_want0(w_sb[2].dir == DIR_E || w_sb[2].dir == DIR_W),
        .i_want1(w_sb[3].dir == DIR_E || w_sb[3].dir == DIR_W),
        .i_prio(r_prio), .o_lane0(w_b0), .o_lane1(w_b1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a0 <= '0;
            r_a1 <= '0;
            r_b0 <= '0;
            r_b1 <= '0;
        end else begin
            r_a0 <= w_a0;
            r_a1 <= w_a1;
            r_b0 <= w_b0;
            r_b1 <= w_b1;
        end
    end

    assign w_ca = '{flit: r_a0.flit, dir: r_a0.dir};
    assign w_cb = '{flit: r_b0.flit, dir: r_b0.dir};
    assign w_da = '{flit: r_a1.flit, dir: r_a1.dir};
    assign w_db = '{flit: r_b1.flit, dir: r_b1.dir};

    // Paired lanes were filled in the same cycle, so OR-ing recovers their shared prio.
    perm_arb_2x2 #(.T(lane_t)) u_arb_c (
        .i_d0(w_ca), .i_d1(w_cb),
        .i_v0(r_a0.flit[VALID_B]), .i_v1(r_b0.flit[VALID_B]),
        .i_gold0(r_a0.golden), .i_gold1(r_b0.golden),
        .i_want0(r_a0.dir != DIR_N), .i_want1(r_b0.dir != DIR_N),
        .i_prio(r_a0.prio | r_b0.prio), .o_lane0(w_n), .o_lane1(w_s)
    );

    perm_arb_2x2 #(.T(lane_t)) u_arb_d (
        .i_d0(w_da), .i_d1(w_db),
        .i_v0(r_a1.flit[VALID_B]), .i_v1(r_b1.flit[VALID_B]),
        .i_gold0(r_a1.golden), .i_gold1(r_b1.golden),
        .i_want0(r_a1.dir != DIR_E), .i_want1(r_b1.dir != DIR_E),
        .i_prio(r_a1.prio | r_b1.prio), .o_lane0(w_e), .o_lane1(w_w)
    );

    assign w_defl = 3'(w_n.flit[VALID_B] && w_n.dir != DIR_N)
                  + 3'(w_s.flit[VALID_B] && w_s.dir != DIR_S)
                  + 3'(w_e.flit[VALID_B] && w_e.dir != DIR_E)
                  + 3'(w_w.flit[VALID_B] && w_w.dir != DIR_W);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_nout <= '0;
            r_sout <= '0;
            r_eout <= '0;
            r_wout <= '0;
            r_defl <= '0;
        end else begin
            r_nout <= w_n.flit;
            r_sout <= w_s.flit;
            r_eout <= w_e.flit;
            r_wout <= w_w.flit;
            r_defl <= w_defl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_epoch <= '0;
            r_tag   <= '0;
            r_prio  <= 1'b0;
        end else begin
            r_prio <= ~r_prio;
            if (r_epoch == EP_LAST) begin
                r_epoch <= '0;
                r_tag   <= r_tag + TAG_W'(1);
            end else begin
                r_epoch <= r_epoch + EP_W'(1);
            end
        end
    end

    assign nout       = r_nout;
    assign sout       = r_sout;
    assign eout       = r_eout;
    assign wout       = r_wout;
    assign defl_cnt   = r_defl;
    assign golden_tag = r_tag;

endmodule
